mult_div_unit: RTL and testbench

//  Multi-cycle signed multiply/divide unit for the multicycle CPU datapath (MULT/DIV).

---
 rtl/mult_div_unit_pkg.sv | 22 ++
 rtl/mult_div_unit_sign_fix.sv | 25 ++
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// Module : mult_div_unit_pkg
// Brief  : Shared constants and state encoding for the multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_sign_fix.sv
// ============================================================================
// Module : div_sign_fix
// Brief  : Applies operand signs to the unsigned quotient/remainder magnitudes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             a_neg,
  input  logic             b_neg,
  input  logic [WIDTH-1:0] quo_mag,
  input  logic [WIDTH-1:0] rem_mag,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
  assign rem = a_neg ? -rem_mag : rem_mag;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module : mult_div_unit
// Brief  : Multi-cycle signed Booth multiplier / restoring divider producing HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_fin, r_dz, r_a_neg, r_b_neg;
  // Accumulator {A, Q, q-1}; A carries one guard bit so -2^(W-1) multiplicands cannot overflow.
  logic [2*WIDTH+1:0]   r_acc, w_acc_next;
  logic [WIDTH:0]       r_mcand, w_a_sum;
  logic [WIDTH-1:0]     r_rem, r_quo, r_dvs;
  logic [WIDTH:0]       w_shift, w_diff;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_quo_fix, w_rem_fix;
  logic                 w_last;

  assign w_last   = (r_cnt == c_last);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign div_zero = done && r_dz;

  assign w_a_mag = data_a[WIDTH-1] ? -data_a : data_a;
  assign w_b_mag = data_b[WIDTH-1] ? -data_b : data_b;

  always_comb begin
    w_a_sum = r_acc[2*WIDTH+1:WIDTH+1];
    case (r_acc[1:0])
      2'b01:   w_a_sum = r_acc[2*WIDTH+1:WIDTH+1] + r_mcand;
      2'b10:   w_a_sum = r_acc[2*WIDTH+1:WIDTH+1] - r_mcand;
      default: w_a_sum = r_acc[2*WIDTH+1:WIDTH+1];
    endcase
    w_acc_next = {w_a_sum[WIDTH], w_a_sum, r_acc[WIDTH:1]};
  end

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a_neg   (r_a_neg),
    .b_neg   (r_b_neg),
    .quo_mag (r_quo),
    .rem_mag (r_rem),
    .quo     (w_quo_fix),
    .rem     (w_rem_fix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mult_start)     w_next = ST_MULT;
        else if (div_start) w_next = ST_DIV;
      end
      ST_MULT: if (r_fin)          w_next = ST_DONE;
      ST_DIV:  if (r_dz || r_fin)  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // r_fin marks that all WIDTH steps are done; the following edge commits HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_fin   <= 1'b0;
      r_dz    <= 1'b0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_fin <= 1'b0;
          if (mult_start) begin
            r_acc   <= {{(WIDTH+1){1'b0}}, data_b, 1'b0};
            r_mcand <= {data_a[WIDTH-1], data_a};
            r_dz    <= 1'b0;
          end else if (div_start) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_a_neg <= data_a[WIDTH-1];
            r_b_neg <= data_b[WIDTH-1];
            r_dz    <= (data_b == '0);
          end
        end
        ST_MULT: begin
          if (!r_fin) begin
            r_acc <= w_acc_next;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            r_fin <= w_last;
          end else begin
            {hi, lo} <= r_acc[2*WIDTH:1];
            r_fin    <= 1'b0;
          end
        end
        ST_DIV: begin
          if (!r_dz) begin
            if (!r_fin) begin
              if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
              end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
              end
              r_cnt <= w_last ? '0 : r_cnt + 1'b1;
              r_fin <= w_last;
            end else begin
              hi    <= w_rem_fix;
              lo    <= w_quo_fix;
              r_fin <= 1'b0;
            end
          end
        end
        default: begin
          r_cnt <= '0;
          r_fin <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module : tb_mult_div_unit
// Brief  : Self-checking bench for mult_div_unit against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .data_a     (data_a),
    .data_b     (data_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit signed arithmetic; HI/LO keep their value on divide-by-zero.
  function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ph, input logic [31:0] pl,
                                output logic [31:0] eh, output logic [31:0] el,
                                output bit edz, output int elat);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0;
    elat = 33;
    if (is_mult) begin
      r = sa * sb;
      eh = r[63:32];
      el = r[31:0];
    end else if (b == 32'd0) begin
      eh = ph;
      el = pl;
      edz = 1'b1;
      elat = 1;
    end else begin
      r = sa / sb;
      el = r[31:0];
      r = sa % sb;
      eh = r[31:0];
    end
  endfunction

  // Caller must be at a negedge with the unit idle. Returns at the negedge where done is seen.
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int n, output bit busy_ok);
    mult_start = m;
    div_start  = d;
    data_a     = a;
    data_b     = b;
    @(posedge clk);
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    data_a     = $urandom;
    data_b     = $urandom;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      div_start = (n == inject_at);
      if (n == inject_at) data_b = 32'd0;
      @(negedge clk);
      n++;
    end
    if (!busy) busy_ok = 1'b0;
    div_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({busy, done, div_zero} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/div_zero=%b required 000", {busy, done, div_zero});
    end
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic check_op(input string name, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    bit edz, bok;
    int elat, n;
    model(m, a, b, m_hi, m_lo, eh, el, edz, elat);
    run_op(m, d, a, b, -1, n, bok);
    tests_run++;
    if (hi !== eh || lo !== el || div_zero !== edz) begin
      tests_failed++;
      $display("FAIL %s result: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
               name, hi, lo, div_zero, eh, el, edz);
    end
    tests_run++;
    if (n != elat || !bok) begin
      tests_failed++;
      $display("FAIL %s timing: done after edge t0+%0d busy_ok=%b required t0+%0d busy_ok=1",
               name, n, bok, elat);
    end
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    tests_run++;
    if ({busy, done, div_zero} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s after_done: busy/done/dz=%b required 000", name, {busy, done, div_zero});
    end
  endtask

  task automatic test_mult();
    check_op("mult_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    check_op("mult_min_x_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div();
    check_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    check_op("div_7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    check_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_div_zero();
    check_op("preload_mult", 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    check_op("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0);
  endtask

  task automatic test_both_start();
    int n, extra;
    bit bok;
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 4, n, bok);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd12 || n != 33 || !bok) begin
      tests_failed++;
      $display("FAIL both_start: hi=%h lo=%h lat=%0d busy_ok=%b required hi=0 lo=c lat=33 busy_ok=1",
               hi, lo, n, bok);
    end
    m_hi = 32'd0;
    m_lo = 32'd12;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL both_start_single_done: extra busy/done cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    mult_start = 1'b1;
    data_a = 32'd123;
    data_b = 32'd456;
    @(posedge clk);
    @(negedge clk);
    mult_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({busy, done} !== 2'b00 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy/done=%b hi=%h lo=%h required 00 0 0", {busy, done}, hi, lo);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7);
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el;
    bit edz, bok;
    int elat, n;
    run_op(1'b1, 1'b0, 32'd9, 32'd11, -1, n, bok);
    m_hi = 32'd0;
    m_lo = 32'd99;
    mult_start = 1'b1;
    data_a = 32'd2;
    data_b = 32'd2;
    @(negedge clk);
    mult_start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || lo !== 32'd99) begin
      tests_failed++;
      $display("FAIL start_in_done: busy=%b lo=%h required busy=0 lo=63", busy, lo);
    end
    model(1'b0, 32'hFFFF_FF9C, 32'd7, m_hi, m_lo, eh, el, edz, elat);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, -1, n, bok);
    tests_run++;
    if (hi !== eh || lo !== el || n != elat || !bok) begin
      tests_failed++;
      $display("FAIL back_to_back: hi=%h lo=%h lat=%0d required hi=%h lo=%h lat=%0d",
               hi, lo, n, eh, el, elat);
    end
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit m;
    int sel;
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(1, 9)); end
        3: b = 32'($urandom_range(0, 15)) - 32'd8;
        default: ;
      endcase
      check_op("random", m, ~m, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_both_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
